// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the two-requester shared ALU arbiter.
package alu_share_arb_pkg;

  localparam int ALU_W = 32;

  // Largest legal opcode; anything above decodes as an error
  localparam logic [3:0] OP_MAX = 4'hA;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_SLT  = 4'h2,
    OP_SLTU = 4'h3,
    OP_XOR  = 4'h4,
    OP_OR   = 4'h5,
    OP_AND  = 4'h6,
    OP_SLL  = 4'h7,
    OP_SRL  = 4'h8,
    OP_SRA  = 4'h9,
    OP_LUI  = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational shared ALU. LUI passes operand B through (the upper
// immediate arrives already positioned). Undefined opcodes give zero
// and raise err_o.
module alu_share_arb_alu
  import alu_share_arb_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [ALU_W-1:0] result_o,
  output logic             err_o
);

  // Opcode decode and result selection
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (alu_op_e'(op_i))
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLT:  result_o = {{(ALU_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(ALU_W-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  result_o = a_i ^ b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_SLL:  result_o = a_i << b_i[4:0];
      OP_SRL:  result_o = a_i >> b_i[4:0];
      OP_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
      OP_LUI:  result_o = b_i;
      default: begin
        result_o = '0;
        err_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one ALU; one operation in flight at a time
// (IDLE -> EXEC -> RESP). Tie-break policy: define ALU_ARB_RR_EN for
// round-robin, otherwise requester 0 wins ties (fixed priority).
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0][DATA_W-1:0] req_a_i,
  input  logic [1:0][DATA_W-1:0] req_b_i,
  input  logic [1:0][3:0]        req_op_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_id_o,
  output logic [DATA_W-1:0]      rsp_data_o,
  output logic                   rsp_err_o,
  output logic [CNT_W-1:0]       op_cnt_o
);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant;
  logic              accept;
  logic              rsp_valid;
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic              id_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_err;

`ifdef ALU_ARB_RR_EN
  logic last_q;
`endif

  // State register; reset mid-operation simply drops back to IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, grant vector and response valid
  always_comb begin
    state_d   = state_q;
    grant     = 2'b00;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i == 2'b11) begin
`ifdef ALU_ARB_RR_EN
          grant = last_q ? 2'b01 : 2'b10;
`else
          grant = 2'b01;
`endif
        end else begin
          grant = req_valid_i;
        end
        if (|req_valid_i) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept      = |grant;
  assign req_ready_o = rst_ni ? grant : 2'b00;
  assign rsp_valid_o = rsp_valid;
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign op_cnt_o    = cnt_q;

  // Capture the granted requester's operands so the ALU sees stable inputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      a_q  <= grant[1] ? req_a_i[1]  : req_a_i[0];
      b_q  <= grant[1] ? req_b_i[1]  : req_b_i[0];
      op_q <= grant[1] ? req_op_i[1] : req_op_i[0];
      id_q <= grant[1];
    end
  end

  alu_share_arb_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_res),
    .err_o    (alu_err)
  );

  // Register the ALU result once; it then holds through RESP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      data_q <= alu_res;
      err_q  <= alu_err;
    end
  end

  // Saturating count of completed response handshakes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  cnt_q <= '0;
    else if (rsp_valid && rsp_ready_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

`ifdef ALU_ARB_RR_EN
  // Remember who was granted last so the other side wins the next tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     last_q <= 1'b1;
    else if (accept) last_q <= grant[1];
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb. Tie expectations follow
// ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_share_arb;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][3:0]  req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic [15:0]      op_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  alu_share_arb #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .op_cnt_o    (op_cnt)
  );

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_a[k]  = a;
    req_b[k]  = b;
    req_op[k] = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
    set_req(0, 32'd0, 32'd0, 4'h0);
    set_req(1, 32'd0, 32'd0, 4'h0);
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL rst_ready: got %b expected 00", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd0) begin n_err++; $display("[TB] FAIL rst_data: got %h expected 0", rsp_data); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("[TB] FAIL rst_id: got %b expected 0", rsp_id); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("[TB] FAIL rst_err: got %b expected 0", rsp_err); end
    n_cmp++; if (op_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL rst_cnt: got %0d expected 0", op_cnt); end
    @(negedge clk);
    rst_n = 1'b1; #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL rst_release_ready: got %b expected 01", req_ready); end
    req_valid = 2'b00;
    exp_cnt = '0;
  endtask

  task automatic test_add();
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 2'b01; set_req(0, 32'd5, 32'd7, 4'h0); #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL add_ready: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00; #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_early_valid: got %b expected 0", rsp_valid); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL add_valid: got %b expected 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd12) begin n_err++; $display("[TB] FAIL add_data: got %h expected 0000000c", rsp_data); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("[TB] FAIL add_id: got %b expected 0", rsp_id); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("[TB] FAIL add_err: got %b expected 0", rsp_err); end
    exp_cnt++;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL add_valid_drop: got %b expected 0", rsp_valid); end
    n_cmp++; if (op_cnt !== 16'd1) begin n_err++; $display("[TB] FAIL add_cnt: got %0d expected 1", op_cnt); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [3:0]  vop [8];
    logic [31:0] vres [8];
    logic        verr [8];
    va[0] = 32'hFFFFFFFF; vb[0] = 32'd1;         vop[0] = 4'h2; vres[0] = 32'd1;         verr[0] = 1'b0;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'd1;         vop[1] = 4'h3; vres[1] = 32'd0;         verr[1] = 1'b0;
    va[2] = 32'd1;        vb[2] = 32'd31;        vop[2] = 4'h7; vres[2] = 32'h80000000;  verr[2] = 1'b0;
    va[3] = 32'h80000000; vb[3] = 32'd4;         vop[3] = 4'h8; vres[3] = 32'h08000000;  verr[3] = 1'b0;
    va[4] = 32'hF0F0F0F0; vb[4] = 32'hFF00FF00;  vop[4] = 4'h6; vres[4] = 32'hF000F000;  verr[4] = 1'b0;
    va[5] = 32'h0000FFFF; vb[5] = 32'h00FF0000;  vop[5] = 4'h5; vres[5] = 32'h00FFFFFF;  verr[5] = 1'b0;
    va[6] = 32'h12345678; vb[6] = 32'h9ABCDEF0;  vop[6] = 4'hB; vres[6] = 32'd0;         verr[6] = 1'b1;
    va[7] = 32'hFFFFFFFF; vb[7] = 32'd1;         vop[7] = 4'h0; vres[7] = 32'd0;         verr[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rsp_ready = 1'b1; req_valid = 2'b01; set_req(0, va[i], vb[i], vop[i]); #1;
      n_cmp++; if (op_cnt !== exp_cnt) begin n_err++; $display("[TB] FAIL ops_cnt[%0d]: got %0d expected %0d", i, op_cnt, exp_cnt); end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL ops_valid[%0d]: got %b expected 1", i, rsp_valid); end
      n_cmp++; if (rsp_data !== vres[i]) begin n_err++; $display("[TB] FAIL ops_data[%0d]: got %h expected %h", i, rsp_data, vres[i]); end
      n_cmp++; if (rsp_err !== verr[i]) begin n_err++; $display("[TB] FAIL ops_err[%0d]: got %b expected %b", i, rsp_err, verr[i]); end
      exp_cnt++;
    end
  endtask

  task automatic test_bad_op();
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 2'b10; set_req(1, 32'd123, 32'd456, 4'hC); #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("[TB] FAIL bad_ready: got %b expected 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (rsp_data !== 32'd0) begin n_err++; $display("[TB] FAIL bad_data: got %h expected 0", rsp_data); end
    n_cmp++; if (rsp_err !== 1'b1) begin n_err++; $display("[TB] FAIL bad_err: got %b expected 1", rsp_err); end
    n_cmp++; if (rsp_id !== 1'b1) begin n_err++; $display("[TB] FAIL bad_id: got %b expected 1", rsp_id); end
    exp_cnt++;
    @(negedge clk); #1;
    n_cmp++; if (op_cnt !== exp_cnt) begin n_err++; $display("[TB] FAIL bad_cnt: got %0d expected %0d", op_cnt, exp_cnt); end
  endtask

  task automatic test_tie();
    logic       exp_id [3];
    logic [1:0] exp_rdy [3];
    logic [31:0] exp_dat [3];
`ifdef ALU_ARB_RR_EN
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0;
`else
    exp_id[0] = 1'b0; exp_id[1] = 1'b0; exp_id[2] = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      exp_rdy[i] = exp_id[i] ? 2'b10 : 2'b01;
      exp_dat[i] = exp_id[i] ? 32'hF8000000 : 32'd7;
    end
    @(negedge clk);
    rst_n = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1; exp_cnt = '0;
    set_req(0, 32'd10, 32'd3, 4'h1);
    set_req(1, 32'h80000000, 32'd4, 4'h9);
    rsp_ready = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      n_cmp++; if (req_ready !== exp_rdy[i]) begin n_err++; $display("[TB] FAIL tie_ready[%0d]: got %b expected %b", i, req_ready, exp_rdy[i]); end
      @(negedge clk); #1;
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL tie_exec_ready[%0d]: got %b expected 00", i, req_ready); end
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL tie_valid[%0d]: got %b expected 1", i, rsp_valid); end
      n_cmp++; if (rsp_id !== exp_id[i]) begin n_err++; $display("[TB] FAIL tie_id[%0d]: got %b expected %b", i, rsp_id, exp_id[i]); end
      n_cmp++; if (rsp_data !== exp_dat[i]) begin n_err++; $display("[TB] FAIL tie_data[%0d]: got %h expected %h", i, rsp_data, exp_dat[i]); end
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL tie_resp_ready[%0d]: got %b expected 00", i, req_ready); end
      exp_cnt++;
    end
    @(negedge clk);
    req_valid = 2'b00; #1;
    n_cmp++; if (op_cnt !== exp_cnt) begin n_err++; $display("[TB] FAIL tie_cnt: got %0d expected %0d", op_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 2'b10;
    set_req(1, 32'hF0F0F0F0, 32'h0FF00FF0, 4'h4);
    set_req(0, 32'd1, 32'd1, 4'h0); #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("[TB] FAIL bp_ready: got %b expected 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, rsp_valid); end
      n_cmp++; if (rsp_data !== 32'hFF00FF00) begin n_err++; $display("[TB] FAIL bp_data[%0d]: got %h expected ff00ff00", i, rsp_data); end
      n_cmp++; if (rsp_id !== 1'b1) begin n_err++; $display("[TB] FAIL bp_id[%0d]: got %b expected 1", i, rsp_id); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("[TB] FAIL bp_err[%0d]: got %b expected 0", i, rsp_err); end
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL bp_req_ready[%0d]: got %b expected 00", i, req_ready); end
      n_cmp++; if (op_cnt !== exp_cnt) begin n_err++; $display("[TB] FAIL bp_cnt[%0d]: got %0d expected %0d", i, op_cnt, exp_cnt); end
    end
    rsp_ready = 1'b1; req_valid = 2'b00;
    exp_cnt++;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (op_cnt !== exp_cnt) begin n_err++; $display("[TB] FAIL bp_release_cnt: got %0d expected %0d", op_cnt, exp_cnt); end
  endtask

  task automatic test_reset_exec();
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 2'b10; set_req(1, 32'h0000000F, 32'h000000F0, 4'h5);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (rsp_data !== 32'hFF) begin n_err++; $display("[TB] FAIL rx_pre_data: got %h expected 000000ff", rsp_data); end
    exp_cnt++;
    @(negedge clk);
    req_valid = 2'b01; set_req(0, 32'd2, 32'd2, 4'h0);
    @(negedge clk);
    rst_n = 1'b0; #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rx_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'd0) begin n_err++; $display("[TB] FAIL rx_data: got %h expected 0", rsp_data); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("[TB] FAIL rx_id: got %b expected 0", rsp_id); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("[TB] FAIL rx_err: got %b expected 0", rsp_err); end
    n_cmp++; if (op_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL rx_cnt: got %0d expected 0", op_cnt); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL rx_ready: got %b expected 00", req_ready); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b00; exp_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rx_post_valid[%0d]: got %b expected 0", i, rsp_valid); end
      n_cmp++; if (op_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL rx_post_cnt[%0d]: got %0d expected 0", i, op_cnt); end
    end
  endtask

  // Sequence the scenarios and report
  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_bad_op();
    test_tie();
    test_backpressure();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
